// File: rtl/sync_fifo_lvl_if.sv
// Handshake/data bundle for sync_fifo_lvl: flush, write, read and status outputs.
// Clock and reset are kept outside the interface as plain ports.
interface sync_fifo_lvl_if #(
  parameter int Bsize = 8,
  parameter int Asize = 8
);
  logic             nClr;
  logic             nWr;
  logic [Bsize-1:0] Din;
  logic             nRd;
  logic [Bsize-1:0] Dout;
  logic             Full;
  logic             Empty;
  logic             Almost_Full;
  logic             Almost_Empty;
  logic [Asize:0]   Level;
  logic             Overflow;
  logic             Underflow;

  modport master (
    output nClr, nWr, Din, nRd,
    input  Dout, Full, Empty, Almost_Full, Almost_Empty, Level, Overflow, Underflow
  );

  modport slave (
    input  nClr, nWr, Din, nRd,
    output Dout, Full, Empty, Almost_Full, Almost_Empty, Level, Overflow, Underflow
  );
endinterface

// File: rtl/sync_fifo_lvl.sv
// Single-clock FWFT FIFO with occupancy count, almost-full/empty thresholds and flush.
// Define FIFO_ERR_FLAGS_EN to build the sticky Overflow/Underflow registers.
module sync_fifo_lvl #(
  parameter int Bsize     = 8,
  parameter int Asize     = 8,
  parameter int Afull_Th  = 2**Asize - 4,
  parameter int Aempty_Th = 4
) (
  input  logic          Clk,
  input  logic          nRst,
  sync_fifo_lvl_if.slave bus
);
  localparam int             Dsize    = 1 << Asize;
  localparam logic [Asize:0] DSIZE_L  = (Asize+1)'(Dsize);
  localparam logic [Asize:0] AFULL_L  = (Asize+1)'(Afull_Th);
  localparam logic [Asize:0] AEMPTY_L = (Asize+1)'(Aempty_Th);
  localparam logic [Asize:0] LVL_ONE  = (Asize+1)'(1);
  localparam logic [Asize-1:0] PTR_ONE = Asize'(1);

  logic [Bsize-1:0] mem_q [Dsize];
  logic [Asize-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Asize:0]   lvl_q, lvl_d;
  logic             full_q, empty_q, afull_q, aempty_q;
  logic             wr_en, rd_en, flush;

  assign flush = ~bus.nClr;
  assign wr_en = ~bus.nWr & ~full_q;
  assign rd_en = ~bus.nRd & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      lvl_d    = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_en && !rd_en)      lvl_d = lvl_q + LVL_ONE;
      else if (rd_en && !wr_en) lvl_d = lvl_q - LVL_ONE;
    end
  end

  // Storage is never reset or cleared; flush only moves the pointers.
  always_ff @(posedge Clk) begin
    if (wr_en && !flush) mem_q[wr_ptr_q] <= bus.Din;
  end

  // Flags are registered from lvl_d so they line up exactly with Level.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
      full_q   <= (lvl_d == DSIZE_L);
      empty_q  <= (lvl_d == '0);
      afull_q  <= (lvl_d >= AFULL_L);
      aempty_q <= (lvl_d <= AEMPTY_L);
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // A read ignored during write-on-empty still counts as an underflow.
  always_comb begin
    ovf_d = ovf_q | (~bus.nWr & full_q);
    udf_d = udf_q | (~bus.nRd & empty_q);
    if (flush) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = udf_q;
`else
  assign bus.Overflow  = 1'b0;
  assign bus.Underflow = 1'b0;
`endif

  assign bus.Dout         = mem_q[rd_ptr_q];
  assign bus.Full         = full_q;
  assign bus.Empty        = empty_q;
  assign bus.Almost_Full  = afull_q;
  assign bus.Almost_Empty = aempty_q;
  assign bus.Level        = lvl_q;
endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Randomized self-checking bench for sync_fifo_lvl (Asize=4, Afull_Th=12, Aempty_Th=4)
// against a queue-based occupancy model.
module tb_sync_fifo_lvl;
  localparam int BS = 8;
  localparam int AS = 4;
  localparam int DEPTH = 16;
  localparam int AF_TH = 12;
  localparam int AE_TH = 4;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic Clk, nRst;
  sync_fifo_lvl_if #(.Bsize(BS), .Asize(AS)) bus ();

  sync_fifo_lvl #(.Bsize(BS), .Asize(AS), .Afull_Th(AF_TH), .Aempty_Th(AE_TH)) dut (
    .Clk (Clk),
    .nRst(nRst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [BS-1:0] q[$];
  bit m_ovf, m_udf;

  // Applies one edge of stimulus and advances the model; returns at posedge+1.
  task automatic cyc(input logic nwr, input logic nrd, input logic nclr, input logic [BS-1:0] din);
    bit full, empty, wr, rd;
    bus.nWr = nwr; bus.nRd = nrd; bus.nClr = nclr; bus.Din = din;
    @(posedge Clk);
    if (!nclr) begin
      q.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      wr = !nwr && !full;
      rd = !nrd && !empty;
      if (ERR_EN && !nwr && full)  m_ovf = 1;
      if (ERR_EN && !nrd && empty) m_udf = 1;
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(din);
    end
    #1;
    bus.nWr = 1'b1; bus.nRd = 1'b1; bus.nClr = 1'b1;
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    bus.nWr = 1'b1; bus.nRd = 1'b1; bus.nClr = 1'b1; bus.Din = '0;
    q.delete(); m_ovf = 0; m_udf = 0;
    repeat (2) @(posedge Clk);
    #1;
    n_chk++; if (bus.Level !== 5'd0) $display("FAIL rst_level got %0d want 0", bus.Level); else n_pass++;
    n_chk++; if (bus.Empty !== 1'b1) $display("FAIL rst_empty got %b want 1", bus.Empty); else n_pass++;
    n_chk++; if (bus.Full !== 1'b0) $display("FAIL rst_full got %b want 0", bus.Full); else n_pass++;
    n_chk++; if (bus.Almost_Empty !== 1'b1) $display("FAIL rst_aempty got %b want 1", bus.Almost_Empty); else n_pass++;
    n_chk++; if (bus.Almost_Full !== 1'b0) $display("FAIL rst_afull got %b want 0", bus.Almost_Full); else n_pass++;
    n_chk++; if ({bus.Overflow, bus.Underflow} !== 2'b00) $display("FAIL rst_err got %b%b want 00", bus.Overflow, bus.Underflow); else n_pass++;
    nRst = 1'b1;
    cyc(1, 1, 1, '0);
    n_chk++; if (bus.Level !== 5'd0 || bus.Empty !== 1'b1) $display("FAIL idle got lvl=%0d empty=%b want 0/1", bus.Level, bus.Empty); else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 1, BS'(i));
      n_chk++; if (bus.Level !== 5'(i + 1)) $display("FAIL fill_level[%0d] got %0d want %0d", i, bus.Level, i + 1); else n_pass++;
      n_chk++; if (bus.Almost_Full !== (i + 1 >= AF_TH)) $display("FAIL fill_afull[%0d] got %b want %b", i, bus.Almost_Full, i + 1 >= AF_TH); else n_pass++;
      n_chk++; if (bus.Full !== (i + 1 == DEPTH)) $display("FAIL fill_full[%0d] got %b want %b", i, bus.Full, i + 1 == DEPTH); else n_pass++;
      n_chk++; if (bus.Almost_Empty !== (i + 1 <= AE_TH)) $display("FAIL fill_aempty[%0d] got %b want %b", i, bus.Almost_Empty, i + 1 <= AE_TH); else n_pass++;
    end
    cyc(0, 1, 1, 8'hEE);
    n_chk++; if (bus.Level !== 5'd16) $display("FAIL ovf_level got %0d want 16", bus.Level); else n_pass++;
    n_chk++; if (bus.Overflow !== ERR_EN) $display("FAIL ovf_flag got %b want %b", bus.Overflow, ERR_EN); else n_pass++;
    n_chk++; if (bus.Dout !== 8'h00) $display("FAIL ovf_head got %h want 00", bus.Dout); else n_pass++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      n_chk++; if (bus.Dout !== BS'(i)) $display("FAIL drain_dout[%0d] got %h want %h", i, bus.Dout, BS'(i)); else n_pass++;
      cyc(1, 0, 1, '0);
      n_chk++; if (bus.Level !== 5'(q.size())) $display("FAIL drain_level[%0d] got %0d want %0d", i, bus.Level, q.size()); else n_pass++;
    end
    n_chk++; if (bus.Empty !== 1'b1) $display("FAIL drain_empty got %b want 1", bus.Empty); else n_pass++;
    cyc(1, 0, 1, '0);
    n_chk++; if (bus.Level !== 5'd0) $display("FAIL udf_level got %0d want 0", bus.Level); else n_pass++;
    n_chk++; if (bus.Underflow !== ERR_EN) $display("FAIL udf_flag got %b want %b", bus.Underflow, ERR_EN); else n_pass++;
  endtask

  task automatic test_back_to_back();
    cyc(1, 1, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, BS'($urandom));
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 1, BS'($urandom));
      n_chk++; if (bus.Dout !== q[0]) $display("FAIL b2b_dout[%0d] got %h want %h", i, bus.Dout, q[0]); else n_pass++;
      n_chk++; if (bus.Level !== 5'd5) $display("FAIL b2b_level[%0d] got %0d want 5", i, bus.Level); else n_pass++;
      n_chk++; if ({bus.Full, bus.Empty, bus.Almost_Full, bus.Almost_Empty, bus.Overflow, bus.Underflow} !== 6'b000000)
        $display("FAIL b2b_flags[%0d] got %b%b%b%b%b%b want 000000", i, bus.Full, bus.Empty, bus.Almost_Full,
                 bus.Almost_Empty, bus.Overflow, bus.Underflow); else n_pass++;
    end
  endtask

  task automatic test_empty_rw();
    cyc(1, 1, 0, '0);
    cyc(0, 0, 1, 8'hA5);
    n_chk++; if (bus.Level !== 5'd1) $display("FAIL erw_level got %0d want 1", bus.Level); else n_pass++;
    n_chk++; if (bus.Dout !== 8'hA5) $display("FAIL erw_dout got %h want a5", bus.Dout); else n_pass++;
    n_chk++; if (bus.Empty !== 1'b0) $display("FAIL erw_empty got %b want 0", bus.Empty); else n_pass++;
    n_chk++; if (bus.Underflow !== ERR_EN) $display("FAIL erw_udf got %b want %b", bus.Underflow, ERR_EN); else n_pass++;
  endtask

  task automatic test_flush();
    cyc(1, 1, 0, '0);
    cyc(1, 0, 1, '0);
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 1, 1, BS'($urandom));
    for (int i = 0; i < 7; i++) cyc(1, 0, 1, '0);
    n_chk++; if (bus.Level !== 5'd9) $display("FAIL pre_flush_level got %0d want 9", bus.Level); else n_pass++;
    n_chk++; if ({bus.Overflow, bus.Underflow} !== {ERR_EN, ERR_EN}) $display("FAIL pre_flush_err got %b%b want %b%b",
             bus.Overflow, bus.Underflow, ERR_EN, ERR_EN); else n_pass++;
    cyc(0, 0, 0, 8'h3C);
    n_chk++; if (bus.Level !== 5'd0 || bus.Empty !== 1'b1 || bus.Full !== 1'b0 || bus.Almost_Empty !== 1'b1)
      $display("FAIL flush_state got lvl=%0d e=%b f=%b ae=%b want 0/1/0/1", bus.Level, bus.Empty, bus.Full, bus.Almost_Empty); else n_pass++;
    n_chk++; if ({bus.Overflow, bus.Underflow} !== 2'b00) $display("FAIL flush_err got %b%b want 00", bus.Overflow, bus.Underflow); else n_pass++;
    // Refill, then pulse reset between edges and check it acts without a clock.
    for (int i = 0; i < 9; i++) cyc(0, 1, 1, BS'($urandom));
    cyc(1, 0, 1, '0);
    cyc(0, 1, 1, '0);
    #2 nRst = 1'b0;
    #1;
    q.delete(); m_ovf = 0; m_udf = 0;
    n_chk++; if (bus.Level !== 5'd0 || bus.Empty !== 1'b1 || bus.Almost_Full !== 1'b0)
      $display("FAIL async_rst got lvl=%0d e=%b af=%b want 0/1/0", bus.Level, bus.Empty, bus.Almost_Full); else n_pass++;
    @(negedge Clk);
    nRst = 1'b1;
    cyc(1, 1, 1, '0);
    n_chk++; if (bus.Level !== 5'd0 || {bus.Overflow, bus.Underflow} !== 2'b00)
      $display("FAIL post_rst got lvl=%0d err=%b%b want 0/00", bus.Level, bus.Overflow, bus.Underflow); else n_pass++;
  endtask

  task automatic test_random();
    logic nwr, nrd, nclr;
    int sz;
    for (int i = 0; i < 400; i++) begin
      nwr  = ($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1;
      nrd  = ($urandom_range(0, 99) < 45) ? 1'b0 : 1'b1;
      nclr = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      cyc(nwr, nrd, nclr, BS'($urandom));
      sz = q.size();
      n_chk++;
      if (bus.Level !== 5'(sz) || bus.Full !== (sz == DEPTH) || bus.Empty !== (sz == 0) ||
          bus.Almost_Full !== (sz >= AF_TH) || bus.Almost_Empty !== (sz <= AE_TH) ||
          bus.Overflow !== m_ovf || bus.Underflow !== m_udf || (sz != 0 && bus.Dout !== q[0]))
        $display("FAIL rand[%0d] got lvl=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b d=%h want lvl=%0d ov=%b un=%b d=%h",
                 i, bus.Level, bus.Full, bus.Empty, bus.Almost_Full, bus.Almost_Empty, bus.Overflow, bus.Underflow,
                 bus.Dout, sz, m_ovf, m_udf, (sz != 0) ? q[0] : 8'h00);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_empty_rw();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
